pc_sequencer: RTL and testbench



---
 rtl/mips_pkg.sv | 27 ++
 rtl/pc_mux.sv | 13 +
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: PC source codes, sequencer states, default vectors.
package mips_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_BR  = 2'b01,
    SEL_JMP = 2'b10,
    SEL_EXC = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_FETCH = 2'b01,
    S_HOLD  = 2'b10
  } seq_state_t;

  // Redirect that arrived while PC could not move.
  typedef struct packed {
    logic        vld;
    pc_sel_t     sel;
    logic [31:0] tgt;
  } redir_t;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0180;

endpackage

// File: rtl/pc_mux.sv
// Two-input PC mux; b wins when sel_b is high.
module pc_mux #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel_b,
  output logic [W-1:0] y
);

  assign y = sel_b ? b : a;

endmodule

// File: rtl/pc_sequencer.sv
// MIPS fetch-stage PC owner: next-PC arbitration, imem req/ack handshake,
// stall hold and buffering of redirects that cannot be applied yet.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VEC_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VEC_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Exception,
  input  logic        FetchAck,
  output logic        FetchReq,
  output logic [31:0] FetchAddr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [1:0]  PCSel,
  output logic        Flush
);

  seq_state_t  state;
  redir_t      pend;
  logic [33:0] br_jmp, live;
  logic        redirect, advance, keep_pend;
  pc_sel_t     next_sel;
  logic [31:0] next_tgt;

  assign PCPlus4   = PC + 32'd4;
  assign FetchAddr = PC;

  // Live redirects carry their source code alongside the target.
  pc_mux #(.W(34)) u_mux_bj (
    .a    ({SEL_BR, BranchTarget}),
    .b    ({SEL_JMP, JumpTarget}),
    .sel_b(Jump),
    .y    (br_jmp)
  );

  pc_mux #(.W(34)) u_mux_exc (
    .a    (br_jmp),
    .b    ({SEL_EXC, EXC_VECTOR}),
    .sel_b(Exception),
    .y    (live)
  );

  assign redirect  = Exception | Jump | BranchTaken;
  assign advance   = ((state == S_FETCH) && FetchAck && !Stall) ||
                     ((state == S_HOLD) && !Stall);
  // A buffered exception survives any later non-exception pulse.
  assign keep_pend = pend.vld && (pend.sel == SEL_EXC) && !Exception;

  always_comb begin
    next_sel = SEL_SEQ;
    next_tgt = PCPlus4;
    if (redirect) begin
      next_sel = pc_sel_t'(live[33:32]);
      next_tgt = live[31:0];
    end else if (pend.vld) begin
      next_sel = pend.sel;
      next_tgt = pend.tgt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_BOOT;
      PC       <= RESET_VECTOR;
      FetchReq <= 1'b0;
      PCSel    <= SEL_SEQ;
      Flush    <= 1'b0;
      pend     <= '0;
    end else begin
      Flush <= 1'b0;
      if (advance) begin
        PC       <= {next_tgt[31:2], 2'b00};
        PCSel    <= next_sel;
        Flush    <= (next_sel != SEL_SEQ);
        pend     <= '0;
      end else if (redirect && !keep_pend) begin
        pend.vld <= 1'b1;
        pend.sel <= pc_sel_t'(live[33:32]);
        pend.tgt <= live[31:0];
      end

      case (state)
        S_BOOT: begin
          state    <= S_FETCH;
          FetchReq <= 1'b1;
        end
        S_FETCH: begin
          if (FetchAck && Stall) begin
            state    <= S_HOLD;
            FetchReq <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!Stall) begin
            state    <= S_FETCH;
            FetchReq <= 1'b1;
          end
        end
        default: begin
          state    <= S_BOOT;
          FetchReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_V = 32'h0000_0000;
  localparam logic [31:0] EXC_V = 32'h8000_0180;

  logic        Clk = 1'b0;
  logic        Reset, Stall, BranchTaken, Jump, Exception, FetchAck;
  logic [31:0] BranchTarget, JumpTarget;
  logic        FetchReq, Flush;
  logic [31:0] FetchAddr, PC, PCPlus4;
  logic [1:0]  PCSel;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: mode 0=boot 1=fetching 2=holding
  int          m_mode;
  logic [31:0] m_pc;
  logic [1:0]  m_sel;
  logic        m_flush;
  logic        p_v;
  logic [31:0] p_tgt;
  logic [1:0]  p_sel;

  always #5 Clk = ~Clk;

  pc_sequencer #(.RESET_VECTOR(RST_V), .EXC_VECTOR(EXC_V)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .Exception(Exception), .FetchAck(FetchAck), .FetchReq(FetchReq),
    .FetchAddr(FetchAddr), .PC(PC), .PCPlus4(PCPlus4), .PCSel(PCSel), .Flush(Flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = RST_V; m_sel = 2'b00; m_flush = 1'b0;
    p_v = 1'b0; p_tgt = '0; p_sel = 2'b00;
  endtask

  task automatic model_update();
    logic        moves;
    logic [31:0] t;
    logic [1:0]  s;
    if (Reset) begin
      model_reset();
      return;
    end
    moves = (m_mode == 1 && FetchAck && !Stall) || (m_mode == 2 && !Stall);
    if (Exception)        begin t = EXC_V;        s = 2'd3; end
    else if (Jump)        begin t = JumpTarget;   s = 2'd2; end
    else if (BranchTaken) begin t = BranchTarget; s = 2'd1; end
    else if (p_v)         begin t = p_tgt;        s = p_sel; end
    else                  begin t = m_pc + 32'd4; s = 2'd0; end
    m_flush = 1'b0;
    if (moves) begin
      m_pc = t & 32'hFFFF_FFFC;
      m_sel = s;
      m_flush = (s != 2'd0);
      p_v = 1'b0;
    end else if ((Exception || Jump || BranchTaken) &&
                 !(p_v && p_sel == 2'd3 && !Exception)) begin
      p_v = 1'b1; p_tgt = t; p_sel = s;
    end
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1 && FetchAck && Stall) m_mode = 2;
    else if (m_mode == 2 && !Stall) m_mode = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    PC,        m_pc);
    chk({tag, ".addr"},  FetchAddr, m_pc);
    chk({tag, ".pc4"},   PCPlus4,   m_pc + 32'd4);
    chk({tag, ".req"},   {31'd0, FetchReq}, {31'd0, (m_mode == 1)});
    chk({tag, ".sel"},   {30'd0, PCSel},    {30'd0, m_sel});
    chk({tag, ".flush"}, {31'd0, Flush},    {31'd0, m_flush});
  endtask

  // Called at a negedge: drive, clock, update model, check at next negedge.
  task automatic step(input string tag, input logic rst, st, br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic ex, ack);
    Reset = rst; Stall = st; BranchTaken = br; BranchTarget = bt;
    Jump = j; JumpTarget = jt; Exception = ex; FetchAck = ack;
    @(posedge Clk);
    model_update();
    @(negedge Clk);
    check_all(tag);
  endtask

  initial begin
    Reset = 1'b1; Stall = 0; BranchTaken = 0; Jump = 0; Exception = 0; FetchAck = 0;
    BranchTarget = '0; JumpTarget = '0;
    model_reset();
    repeat (2) @(negedge Clk);
    check_all("reset");

    // Boot then sequential fetch with ack tied high
    step("boot", 0, 0, 0, 0, 0, 0, 0, 1);
    chk("boot_pc", PC, 32'h0);
    step("seq1", 0, 0, 0, 0, 0, 0, 0, 1);
    chk("seq_pc4", PC, 32'h4);
    step("seq2", 0, 0, 0, 0, 0, 0, 0, 1);
    chk("seq_pc8", PC, 32'h8);

    // Branch at PC=8 with misaligned target
    step("br", 0, 0, 1, 32'h0000_0103, 0, 0, 0, 1);
    chk("br_pc", PC, 32'h0000_0100);
    chk("br_sel", {30'd0, PCSel}, 32'd1);
    chk("br_flush", {31'd0, Flush}, 32'd1);
    step("br_after", 0, 0, 0, 0, 0, 0, 0, 1);
    chk("br_flush_drop", {31'd0, Flush}, 32'd0);

    // Jump while ack is withheld: address holds, jump applies on ack
    step("jw0", 0, 0, 0, 0, 1, 32'h0040_0000, 0, 0);
    step("jw1", 0, 0, 0, 0, 0, 0, 0, 0);
    step("jw2", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("jw_addr", FetchAddr, 32'h0000_0104);
    step("jack", 0, 0, 0, 0, 0, 0, 0, 1);
    chk("jmp_pc", PC, 32'h0040_0000);
    chk("jmp_sel", {30'd0, PCSel}, 32'd2);

    // Stall into hold; branch then exception; exception wins
    step("h0", 0, 1, 0, 0, 0, 0, 0, 1);
    step("h1", 0, 1, 1, 32'h0000_1234, 0, 0, 0, 0);
    step("h2", 0, 1, 0, 0, 0, 0, 1, 0);
    step("h3", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("exc_pc", PC, EXC_V);
    chk("exc_sel", {30'd0, PCSel}, 32'd3);

    // Pending exception not displaced by a later branch
    step("k0", 0, 1, 0, 0, 0, 0, 0, 1);
    step("k1", 0, 1, 0, 0, 0, 0, 1, 0);
    step("k2", 0, 1, 1, 32'h0000_2000, 0, 0, 0, 0);
    step("k3", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("keep_exc_pc", PC, EXC_V);

    // Wrap from top of address space
    step("w0", 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    step("w1", 0, 0, 0, 0, 0, 0, 0, 1);
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_flush", {31'd0, Flush}, 32'd0);

    // Asynchronous reset mid-fetch with ack pending
    FetchAck = 1'b1;
    #2 Reset = 1'b1;
    #1;
    chk("arst_req", {31'd0, FetchReq}, 32'd0);
    chk("arst_pc", PC, RST_V);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    check_all("arst_hold");
    step("arst_boot", 0, 0, 0, 0, 0, 0, 0, 1);
    step("arst_run", 0, 0, 0, 0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step("rnd", ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), $urandom,
           ($urandom_range(0, 11) == 0), $urandom,
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
